// File: rtl/ps2_pkg.sv
// Shared PS/2 receiver types and protocol constants.
package ps2_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } ps2_state_e;

  localparam logic [7:0] PS2_EXT_PREFIX = 8'hE0;
  localparam logic [7:0] PS2_BRK_PREFIX = 8'hF0;

  // start + 8 data + parity + stop
  localparam int PS2_FRAME_LEN = 11;
  localparam int PS2_DATA_BITS = PS2_FRAME_LEN - 3;

endpackage

// File: rtl/ps2_clk_filter.sv
// Two-flop synchroniser, FILTER_LEN-sample majority-free level filter and
// falling-edge pulse for a slow, noisy, asynchronous line.
module ps2_clk_filter #(
  parameter int FILTER_LEN = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic i_raw,
  output logic o_fall
);

  logic [1:0]            r_sync;
  logic [FILTER_LEN-1:0] r_shift;
  logic                  r_filt;
  logic                  r_fall;

  // Sync, shift history, change level only on a unanimous history; fall
  // pulses in the same cycle the filtered level first reads 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync  <= 2'b11;
      r_shift <= '1;
      r_filt  <= 1'b1;
      r_fall  <= 1'b0;
    end else begin
      r_sync  <= {r_sync[0], i_raw};
      r_shift <= {r_shift[FILTER_LEN-2:0], r_sync[1]};
      r_fall  <= 1'b0;
      if (r_shift == '0) begin
        r_filt <= 1'b0;
        r_fall <= r_filt;
      end else if (&r_shift) begin
        r_filt <= 1'b1;
      end
    end
  end

  assign o_fall = r_fall;

endmodule

// File: rtl/ps2_rx.sv
// PS/2 device-to-host receiver: deserialises 11-bit frames, checks framing,
// folds E0/F0 prefixes into flags and strobes one scancode per key event.
import ps2_pkg::*;

module ps2_rx #(
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 10000,
  parameter int TO_W           = 14
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       PS2_CLK,
  input  logic       PS2_DATA,
  output logic [7:0] code,
  output logic       code_valid,
  output logic       is_ext,
  output logic       is_break,
  output logic       frame_err
);

  logic [1:0]      r_dsync;
  logic            w_data;
  logic            w_fall;
  ps2_state_e      r_state, w_state_nxt;
  logic [2:0]      r_bit_cnt;
  logic [7:0]      r_shift;
  logic            r_parity;
  logic [TO_W-1:0] r_to_cnt;
  logic            r_ext_pend, r_brk_pend;
  logic            w_timeout, w_stop_fall, w_frame_ok;

  ps2_clk_filter #(.FILTER_LEN(FILTER_LEN)) u_clk_filter (
    .clk    (clk),
    .rst    (rst),
    .i_raw  (PS2_CLK),
    .o_fall (w_fall)
  );

  // Data only needs synchronising; it is stable long before the clock falls.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_dsync <= 2'b11;
    else     r_dsync <= {r_dsync[0], PS2_DATA};
  end

  assign w_data = r_dsync[1];

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_nxt;
  end

  // Next state; a fall in the same cycle as timeout expiry wins.
  always_comb begin
    w_state_nxt = r_state;
    w_timeout   = 1'b0;
    w_stop_fall = 1'b0;
    if (r_state != ST_IDLE && !w_fall && r_to_cnt == TO_W'(TIMEOUT_CYCLES)) begin
      w_timeout   = 1'b1;
      w_state_nxt = ST_IDLE;
    end else if (w_fall) begin
      unique case (r_state)
        ST_IDLE:   if (!w_data) w_state_nxt = ST_DATA;
        ST_DATA:   if (r_bit_cnt == 3'(PS2_DATA_BITS - 1)) w_state_nxt = ST_PARITY;
        ST_PARITY: w_state_nxt = ST_STOP;
        ST_STOP: begin
          w_state_nxt = ST_IDLE;
          w_stop_fall = 1'b1;
        end
        default:   w_state_nxt = ST_IDLE;
      endcase
    end
  end

  // Valid frame: stop bit high and odd parity over data + parity bit.
  assign w_frame_ok = w_data & (^{r_shift, r_parity});

  // Bit capture (LSB first) and inter-edge timeout counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_bit_cnt <= '0;
      r_shift   <= '0;
      r_parity  <= 1'b0;
      r_to_cnt  <= '0;
    end else begin
      if (w_fall) begin
        case (r_state)
          ST_IDLE: r_bit_cnt <= '0;
          ST_DATA: begin
            r_shift   <= {w_data, r_shift[7:1]};
            r_bit_cnt <= r_bit_cnt + 3'd1;
          end
          ST_PARITY: r_parity <= w_data;
          default: ;
        endcase
      end
      if (r_state == ST_IDLE || w_fall) r_to_cnt <= '0;
      else                              r_to_cnt <= r_to_cnt + 1'b1;
    end
  end

  // Prefix folding, scancode/flag outputs and one-cycle strobes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      code       <= '0;
      code_valid <= 1'b0;
      is_ext     <= 1'b0;
      is_break   <= 1'b0;
      frame_err  <= 1'b0;
      r_ext_pend <= 1'b0;
      r_brk_pend <= 1'b0;
    end else begin
      code_valid <= 1'b0;
      frame_err  <= 1'b0;
      if (w_timeout) begin
        frame_err  <= 1'b1;
        r_ext_pend <= 1'b0;
        r_brk_pend <= 1'b0;
      end else if (w_stop_fall) begin
        if (!w_frame_ok) begin
          frame_err  <= 1'b1;
          r_ext_pend <= 1'b0;
          r_brk_pend <= 1'b0;
        end else if (r_shift == PS2_EXT_PREFIX) begin
          r_ext_pend <= 1'b1;
        end else if (r_shift == PS2_BRK_PREFIX) begin
          r_brk_pend <= 1'b1;
        end else begin
          code       <= r_shift;
          is_ext     <= r_ext_pend;
          is_break   <= r_brk_pend;
          code_valid <= 1'b1;
          r_ext_pend <= 1'b0;
          r_brk_pend <= 1'b0;
        end
      end
    end
  end

endmodule
